// File: rtl/qp_pkg.sv
// Shared definitions for quick_page clients: function/status codes, requester FSM
// states, the command payload and its legality check.
package qp_pkg;

    localparam int unsigned LINE_S  = 4;
    localparam int unsigned BLOCK_D = 8;
    localparam int unsigned REQ_S   = BLOCK_D * LINE_S;
    localparam int unsigned REQ_W   = $clog2(REQ_S) + 1;
    localparam int unsigned REP_W   = 9;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 64;

    typedef enum logic [1:0] {
        f_IDLE     = 2'b00,
        f_ALLOC    = 2'b01,
        f_DEALLOC  = 2'b10,
        f_RESERVED = 2'b11
    } func_e;

    typedef enum logic [1:0] {
        s_OK      = 2'b00,
        s_REJECT  = 2'b01,
        s_TIMEOUT = 2'b10,
        s_FAIL    = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_BUSY = 2'b01,
        WAIT_DONE = 2'b10,
        RESP      = 2'b11
    } state_e;

    typedef struct packed {
        func_e              func;
        logic [REQ_W-1:0]   size;
        logic [REP_W-1:0]   data;
        logic [TAG_W-1:0]   tag;
    } cmd_t;

    // Only alloc with 1..REQ_S bytes and dealloc are forwarded to quick_page
    function automatic logic cmd_legal(input cmd_t c);
        logic ok;
        ok = 1'b0;
        case (c.func)
            f_ALLOC:   ok = (c.size != '0) && (c.size <= REQ_W'(REQ_S));
            f_DEALLOC: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/qp_req_timer.sv
// Clear/enable saturating wait timer; expire_c flags the enabled cycle that
// brings the count to LIMIT.
module qp_req_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != W'(LIMIT))) begin
            count <= count + W'(1);
        end
    end

    assign expire_c = en && !clr && (count >= W'(LIMIT - 1));

endmodule

// File: rtl/qp_requester.sv
// Client-side initiator for quick_page: one outstanding alloc/dealloc at a time,
// driven with the toggling req_id protocol and answered with a status code.
module qp_requester
    import qp_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_vld,
    output logic             o_cmd_rdy,
    input  logic [1:0]       i_cmd_func,
    input  logic [REQ_W-1:0] i_cmd_size,
    input  logic [REP_W-1:0] i_cmd_data,
    input  logic [TAG_W-1:0] i_cmd_tag,
    output logic             o_rsp_vld,
    input  logic             i_rsp_rdy,
    output logic [1:0]       o_rsp_status,
    output logic [REP_W-1:0] o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_req_id,
    output logic [1:0]       o_req_func,
    output logic [REQ_W-1:0] o_req_alloc_size,
    output logic [REP_W-1:0] o_req_dealloc_data,
    input  logic             i_busy,
    input  logic             i_rep_alloc_vld,
    input  logic             i_rep_dealloc_vld,
    input  logic [REP_W-1:0] i_rep_data
);

    state_e           state, state_nxt;
    cmd_t             cmd_in;
    logic             cmd_ok, hit_c, hit_alloc_c;
    logic             tmr_clr, tmr_en, tmr_expire;

    func_e            func_q, func_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             done_q, done_d;
    logic [REP_W-1:0] rep_q, rep_d;

    logic             req_id_d;
    logic [1:0]       req_func_d;
    logic [REQ_W-1:0] req_size_d;
    logic [REP_W-1:0] req_data_d;
    logic             rsp_vld_d;
    logic [1:0]       rsp_status_d;
    logic [REP_W-1:0] rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_d;

    assign cmd_in      = '{func: func_e'(i_cmd_func), size: i_cmd_size,
                           data: i_cmd_data, tag: i_cmd_tag};
    assign cmd_ok      = cmd_legal(cmd_in);
    assign hit_alloc_c = (func_q == f_ALLOC) && i_rep_alloc_vld;
    assign hit_c       = hit_alloc_c || ((func_q == f_DEALLOC) && i_rep_dealloc_vld);
    assign o_cmd_rdy   = (state == IDLE) && !i_reset;

    // Timer restarts on issue and again when busy is first seen
    assign tmr_clr = (state == IDLE) || ((state == WAIT_BUSY) && i_busy);
    assign tmr_en  = (state == WAIT_BUSY) || (state == WAIT_DONE);

    qp_req_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk      (i_clk),
        .reset    (i_reset),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .expire_c (tmr_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state              <= IDLE;
            func_q             <= f_IDLE;
            tag_q              <= '0;
            done_q             <= 1'b0;
            rep_q              <= '0;
            o_req_id           <= 1'b0;
            o_req_func         <= 2'b00;
            o_req_alloc_size   <= '0;
            o_req_dealloc_data <= '0;
            o_rsp_vld          <= 1'b0;
            o_rsp_status       <= 2'b00;
            o_rsp_data         <= '0;
            o_rsp_tag          <= '0;
        end else begin
            state              <= state_nxt;
            func_q             <= func_d;
            tag_q              <= tag_d;
            done_q             <= done_d;
            rep_q              <= rep_d;
            o_req_id           <= req_id_d;
            o_req_func         <= req_func_d;
            o_req_alloc_size   <= req_size_d;
            o_req_dealloc_data <= req_data_d;
            o_rsp_vld          <= rsp_vld_d;
            o_rsp_status       <= rsp_status_d;
            o_rsp_data         <= rsp_data_d;
            o_rsp_tag          <= rsp_tag_d;
        end
    end

    // Busy edges take priority over a coincident timer expiry
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (i_cmd_vld) state_nxt = cmd_ok ? WAIT_BUSY : RESP;
            WAIT_BUSY: if (i_busy) state_nxt = WAIT_DONE;
                       else if (tmr_expire) state_nxt = RESP;
            WAIT_DONE: if (!i_busy || tmr_expire) state_nxt = RESP;
            RESP:      if (i_rsp_rdy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        func_d       = func_q;
        tag_d        = tag_q;
        done_d       = done_q;
        rep_d        = rep_q;
        req_id_d     = o_req_id;
        req_func_d   = o_req_func;
        req_size_d   = o_req_alloc_size;
        req_data_d   = o_req_dealloc_data;
        rsp_vld_d    = o_rsp_vld;
        rsp_status_d = o_rsp_status;
        rsp_data_d   = o_rsp_data;
        rsp_tag_d    = o_rsp_tag;
        unique case (state)
            IDLE: if (i_cmd_vld) begin
                func_d = cmd_in.func;
                tag_d  = cmd_in.tag;
                done_d = 1'b0;
                rep_d  = '0;
                if (cmd_ok) begin
                    req_id_d   = ~o_req_id;
                    req_func_d = cmd_in.func;
                    req_size_d = cmd_in.size;
                    req_data_d = cmd_in.data;
                end else begin
                    rsp_vld_d    = 1'b1;
                    rsp_status_d = s_REJECT;
                    rsp_data_d   = '0;
                    rsp_tag_d    = cmd_in.tag;
                end
            end
            WAIT_BUSY: if (!i_busy && tmr_expire) begin
                req_func_d   = f_IDLE;
                rsp_vld_d    = 1'b1;
                rsp_status_d = s_TIMEOUT;
                rsp_data_d   = '0;
                rsp_tag_d    = tag_q;
            end
            WAIT_DONE: begin
                // Reply pulse may arrive any time before or with busy falling
                if (hit_c)       done_d = 1'b1;
                if (hit_alloc_c) rep_d  = i_rep_data;
                if (!i_busy) begin
                    req_func_d   = f_IDLE;
                    rsp_vld_d    = 1'b1;
                    rsp_status_d = done_d ? s_OK : s_FAIL;
                    rsp_data_d   = (done_d && (func_q == f_ALLOC)) ? rep_d : '0;
                    rsp_tag_d    = tag_q;
                end else if (tmr_expire) begin
                    req_func_d   = f_IDLE;
                    rsp_vld_d    = 1'b1;
                    rsp_status_d = s_TIMEOUT;
                    rsp_data_d   = '0;
                    rsp_tag_d    = tag_q;
                end
            end
            RESP: if (i_rsp_rdy) rsp_vld_d = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qp_requester.sv
// Scoreboard bench for qp_requester with an inline quick_page stub.
module tb_qp_requester;
    import qp_pkg::*;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_cmd_vld;
    logic             o_cmd_rdy;
    logic [1:0]       i_cmd_func;
    logic [REQ_W-1:0] i_cmd_size;
    logic [REP_W-1:0] i_cmd_data;
    logic [TAG_W-1:0] i_cmd_tag;
    logic             o_rsp_vld;
    logic             i_rsp_rdy;
    logic [1:0]       o_rsp_status;
    logic [REP_W-1:0] o_rsp_data;
    logic [TAG_W-1:0] o_rsp_tag;
    logic             o_req_id;
    logic [1:0]       o_req_func;
    logic [REQ_W-1:0] o_req_alloc_size;
    logic [REP_W-1:0] o_req_dealloc_data;
    logic             i_busy;
    logic             i_rep_alloc_vld;
    logic             i_rep_dealloc_vld;
    logic [REP_W-1:0] i_rep_data;

    typedef struct packed {
        logic [1:0]       status;
        logic [REP_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_id   = 1'b0;

    always #5 clk = ~clk;

    qp_requester dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_cmd_vld          (i_cmd_vld),
        .o_cmd_rdy          (o_cmd_rdy),
        .i_cmd_func         (i_cmd_func),
        .i_cmd_size         (i_cmd_size),
        .i_cmd_data         (i_cmd_data),
        .i_cmd_tag          (i_cmd_tag),
        .o_rsp_vld          (o_rsp_vld),
        .i_rsp_rdy          (i_rsp_rdy),
        .o_rsp_status       (o_rsp_status),
        .o_rsp_data         (o_rsp_data),
        .o_rsp_tag          (o_rsp_tag),
        .o_req_id           (o_req_id),
        .o_req_func         (o_req_func),
        .o_req_alloc_size   (o_req_alloc_size),
        .o_req_dealloc_data (o_req_dealloc_data),
        .i_busy             (i_busy),
        .i_rep_alloc_vld    (i_rep_alloc_vld),
        .i_rep_dealloc_vld  (i_rep_dealloc_vld),
        .i_rep_data         (i_rep_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single accepting edge and queue its expected response
    task automatic send_cmd(input logic [1:0] func, input logic [REQ_W-1:0] size,
                            input logic [REP_W-1:0] data, input logic [TAG_W-1:0] tag,
                            input logic [1:0] exp_status, input logic [REP_W-1:0] exp_data,
                            input bit issue);
        exp_q.push_back('{status: exp_status, data: exp_data, tag: tag});
        check("cmd_rdy_idle", 32'(o_cmd_rdy), 32'd1);
        i_cmd_vld  = 1'b1;
        i_cmd_func = func;
        i_cmd_size = size;
        i_cmd_data = data;
        i_cmd_tag  = tag;
        tick();
        i_cmd_vld  = 1'b0;
        if (issue) exp_id = ~exp_id;
        check("req_id", 32'(o_req_id), 32'(exp_id));
        check("req_func_issue", 32'(o_req_func), issue ? 32'(func) : 32'd0);
        if (issue && func == f_ALLOC)   check("req_alloc_size", 32'(o_req_alloc_size), 32'(size));
        if (issue && func == f_DEALLOC) check("req_dealloc_data", 32'(o_req_dealloc_data), 32'(data));
    endtask

    // quick_page stand-in: busy for n edges, reply pulse early (last busy cycle) or with busy falling
    task automatic qp_stub(input int n, input logic a_vld, input logic d_vld,
                           input logic [REP_W-1:0] data, input logic [1:0] func, input bit early);
        i_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (early && i == n - 1) begin
                i_rep_alloc_vld   = a_vld;
                i_rep_dealloc_vld = d_vld;
                i_rep_data        = data;
            end
            tick();
            i_rep_alloc_vld   = 1'b0;
            i_rep_dealloc_vld = 1'b0;
            i_rep_data        = '0;
            check("req_func_wait", 32'(o_req_func), 32'(func));
        end
        i_busy = 1'b0;
        if (!early) begin
            i_rep_alloc_vld   = a_vld;
            i_rep_dealloc_vld = d_vld;
            i_rep_data        = data;
        end
        tick();
        i_rep_alloc_vld   = 1'b0;
        i_rep_dealloc_vld = 1'b0;
        i_rep_data        = '0;
    endtask

    task automatic get_rsp(input int hold);
        int   waited = 0;
        exp_t e;
        exp_t snap;
        while (!o_rsp_vld && waited < 200) begin
            tick();
            waited++;
        end
        if (!o_rsp_vld) begin
            check("rsp_vld_timeout", 32'(o_rsp_vld), 32'd1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            return;
        end
        snap = '{status: o_rsp_status, data: o_rsp_data, tag: o_rsp_tag};
        repeat (hold) begin
            tick();
            check("rsp_stable", 32'({o_rsp_status, o_rsp_data, o_rsp_tag}), 32'(snap));
            check("rsp_vld_held", 32'(o_rsp_vld), 32'd1);
            check("cmd_rdy_in_resp", 32'(o_cmd_rdy), 32'd0);
        end
        if (exp_q.size() == 0) begin
            check("sb_unexpected_rsp", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("rsp_status", 32'(o_rsp_status), 32'(e.status));
        check("rsp_data", 32'(o_rsp_data), 32'(e.data));
        check("rsp_tag", 32'(o_rsp_tag), 32'(e.tag));
        i_rsp_rdy = 1'b1;
        tick();
        i_rsp_rdy = 1'b0;
        check("rsp_vld_drop", 32'(o_rsp_vld), 32'd0);
        check("req_func_after", 32'(o_req_func), 32'd0);
        check("cmd_rdy_after", 32'(o_cmd_rdy), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_id"},   32'(o_req_id), 32'd0);
        check({tag, "_req_func"}, 32'(o_req_func), 32'd0);
        check({tag, "_req_size"}, 32'(o_req_alloc_size), 32'd0);
        check({tag, "_req_data"}, 32'(o_req_dealloc_data), 32'd0);
        check({tag, "_rsp_vld"},  32'(o_rsp_vld), 32'd0);
        check({tag, "_rsp_stat"}, 32'(o_rsp_status), 32'd0);
        check({tag, "_rsp_data"}, 32'(o_rsp_data), 32'd0);
        check({tag, "_rsp_tag"},  32'(o_rsp_tag), 32'd0);
        check({tag, "_cmd_rdy"},  32'(o_cmd_rdy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        i_reset = 1'b1; i_cmd_vld = 1'b0; i_cmd_func = 2'b00; i_cmd_size = '0;
        i_cmd_data = '0; i_cmd_tag = '0; i_rsp_rdy = 1'b0; i_busy = 1'b0;
        i_rep_alloc_vld = 1'b0; i_rep_dealloc_vld = 1'b0; i_rep_data = '0;
        repeat (3) tick();
        check_reset_outputs("por");
        i_reset = 1'b0;
        #1;
        check("cmd_rdy_post_reset", 32'(o_cmd_rdy), 32'd1);

        // Alloc 16 bytes, reply with busy falling
        send_cmd(f_ALLOC, 6'd16, 9'h000, 4'd5, s_OK, 9'h0A4, 1'b1);
        qp_stub(3, 1'b1, 1'b0, 9'h0A4, f_ALLOC, 1'b0);
        get_rsp(0);

        // Size boundaries: 0 and 33 rejected, 32 accepted
        send_cmd(f_ALLOC, 6'd0, 9'h000, 4'd1, s_REJECT, 9'h000, 1'b0);
        check("reject_latency", 32'(o_rsp_vld), 32'd1);
        get_rsp(0);
        send_cmd(f_ALLOC, 6'd33, 9'h000, 4'd2, s_REJECT, 9'h000, 1'b0);
        get_rsp(0);
        send_cmd(f_ALLOC, 6'd32, 9'h000, 4'd3, s_OK, 9'h1FF, 1'b1);
        qp_stub(1, 1'b1, 1'b0, 9'h1FF, f_ALLOC, 1'b0);
        get_rsp(0);

        // Dealloc, then reserved and idle func codes
        send_cmd(f_DEALLOC, 6'd0, 9'h0A4, 4'd6, s_OK, 9'h000, 1'b1);
        qp_stub(2, 1'b0, 1'b1, 9'h0A4, f_DEALLOC, 1'b0);
        get_rsp(0);
        send_cmd(f_RESERVED, 6'd4, 9'h000, 4'd7, s_REJECT, 9'h000, 1'b0);
        get_rsp(0);
        send_cmd(f_IDLE, 6'd4, 9'h000, 4'd8, s_REJECT, 9'h000, 1'b0);
        get_rsp(0);

        // Busy never rises
        send_cmd(f_ALLOC, 6'd8, 9'h000, 4'd9, s_TIMEOUT, 9'h000, 1'b1);
        c = 0;
        while (!o_rsp_vld && c < 200) begin
            tick();
            c++;
        end
        check("timeout_cycles", 32'(c), 32'(TIMEOUT));
        check("timeout_req_func", 32'(o_req_func), 32'd0);
        get_rsp(0);

        // Wrong-kind reply only, response held off 5 cycles
        send_cmd(f_ALLOC, 6'd12, 9'h000, 4'd10, s_FAIL, 9'h000, 1'b1);
        qp_stub(3, 1'b0, 1'b1, 9'h055, f_ALLOC, 1'b0);
        get_rsp(5);

        // Reset in the middle of WAIT_DONE
        send_cmd(f_ALLOC, 6'd4, 9'h000, 4'd11, s_OK, 9'h000, 1'b1);
        i_busy = 1'b1;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_id  = 1'b0;
        i_reset = 1'b0;
        i_busy  = 1'b0;
        #1;
        check("cmd_rdy_after_midreset", 32'(o_cmd_rdy), 32'd1);

        // Reply pulse ahead of busy falling must stick
        send_cmd(f_ALLOC, 6'd20, 9'h000, 4'd12, s_OK, 9'h033, 1'b1);
        qp_stub(3, 1'b1, 1'b0, 9'h033, f_ALLOC, 1'b1);
        get_rsp(2);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
